// File: rtl/tx_duc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_duc_fifo
// Purpose  : CPU-fed I/Q pair FIFO played out at 2^LOG2_INTERP adc_clk per
//            pair. Define TX_INTERP_LINEAR_EN for linear interpolation,
//            otherwise each pair is held (zero-order hold).
// Revision : 1.0  initial release
// ============================================================================
module tx_duc_fifo #(
  parameter int FIFO_AW     = 4,
  parameter int LOG2_INTERP = 5,
  parameter int START_LEVEL = 8
) (
  input  logic               adc_clk,
  input  logic               reset_n,
  input  logic               tx_en,
  input  logic               tx_wr,
  input  logic [31:0]        tx_wdata,
  input  logic               clr_flags,
  output logic [FIFO_AW:0]   tx_level,
  output logic               tx_full,
  output logic               tx_running,
  output logic               tx_avail,
  output logic [15:0]        tx_out_i,
  output logic [15:0]        tx_out_q,
  output logic               tx_underrun,
  output logic               tx_overflow
);

  localparam int               C_DEPTH_N = 1 << FIFO_AW;
  localparam int               C_ACC_W   = 17 + LOG2_INTERP;
  localparam logic [FIFO_AW:0] C_DEPTH   = (FIFO_AW + 1)'(C_DEPTH_N);
  localparam logic [FIFO_AW:0] C_START   = (FIFO_AW + 1)'(START_LEVEL);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 r_state;
  logic [31:0]            r_mem [C_DEPTH_N];
  logic [FIFO_AW-1:0]     r_wr_ptr;
  logic [FIFO_AW-1:0]     r_rd_ptr;
  logic [FIFO_AW:0]       r_level;
  logic [LOG2_INTERP-1:0] r_phase;
  logic                   r_tx_en_q;
  logic                   r_avail;
  logic                   r_underrun;
  logic                   r_overflow;
  logic signed [15:0]     r_cur [2];
  logic [15:0]            r_out [2];

  logic [31:0]            w_rd_data;
  logic [15:0]            w_pop_ch [2];
  logic                   w_flush;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_seg_end;
  logic                   w_pop;
  logic                   w_underrun;

  // The FIFO is flushed on the falling edge of tx_en, so the CPU can still
  // pre-load pairs while playout is disabled.
  assign w_flush    = r_tx_en_q & ~tx_en;
  assign w_full     = (r_level == C_DEPTH);
  assign w_empty    = (r_level == '0);
  assign w_push     = tx_wr & ~w_full & ~w_flush;
  assign w_seg_end  = (r_state == S_RUN) & tx_en & (r_phase == '0);
  assign w_pop      = w_seg_end & ~w_empty;
  assign w_underrun = w_seg_end & w_empty;

  assign w_rd_data   = r_mem[r_rd_ptr];
  assign w_pop_ch[0] = w_rd_data[31:16];
  assign w_pop_ch[1] = w_rd_data[15:0];

`ifdef TX_INTERP_LINEAR_EN
  logic signed [15:0]        r_prev [2];
  logic signed [C_ACC_W-1:0] r_acc  [2];
  logic signed [16:0]        w_diff [2];

  for (genvar c = 0; c < 2; c++) begin : g_diff
    assign w_diff[c] = {r_cur[c][15], r_cur[c]} - {r_prev[c][15], r_prev[c]};
  end
`endif

  always_ff @(posedge adc_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_wdata;
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_avail   <= 1'b0;
      r_tx_en_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        r_cur[c] <= '0;
        r_out[c] <= '0;
`ifdef TX_INTERP_LINEAR_EN
        r_prev[c] <= '0;
        r_acc[c]  <= '0;
`endif
      end
    end else begin
      r_tx_en_q <= tx_en;
      r_avail   <= w_pop;
      if (r_state == S_RUN && tx_en && !w_underrun) begin
        r_phase <= r_phase + 1'b1;
        for (int c = 0; c < 2; c++) begin
          if (w_pop) r_cur[c] <= w_pop_ch[c];
`ifdef TX_INTERP_LINEAR_EN
          r_out[c] <= r_acc[c][LOG2_INTERP +: 16];
          if (w_pop) begin
            r_prev[c] <= r_cur[c];
            r_acc[c]  <= {r_cur[c][15], r_cur[c], {LOG2_INTERP{1'b0}}};
          end else begin
            r_acc[c] <= r_acc[c] + {{LOG2_INTERP{w_diff[c][16]}}, w_diff[c]};
          end
`else
          r_out[c] <= r_cur[c];
`endif
        end
      end else begin
        // Idle, disabled or starved: park the datapath in its RUN-entry state.
        if (r_state == S_IDLE) begin
          if (tx_en && r_level >= C_START) r_state <= S_RUN;
        end else begin
          r_state <= S_IDLE;
        end
        r_phase <= '0;
        for (int c = 0; c < 2; c++) begin
          r_cur[c] <= '0;
          r_out[c] <= '0;
`ifdef TX_INTERP_LINEAR_EN
          r_prev[c] <= '0;
          r_acc[c]  <= '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_underrun)     r_underrun <= 1'b1;
      else if (clr_flags) r_underrun <= 1'b0;
      if (tx_wr && w_full) r_overflow <= 1'b1;
      else if (clr_flags)  r_overflow <= 1'b0;
    end
  end

  assign tx_level    = r_level;
  assign tx_full     = w_full;
  assign tx_running  = (r_state == S_RUN);
  assign tx_avail    = r_avail;
  assign tx_out_i    = r_out[0];
  assign tx_out_q    = r_out[1];
  assign tx_underrun = r_underrun;
  assign tx_overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/tx_duc_fifo.md
# tx_duc_fifo

Transmit-direction counterpart of the receive decimation chain. The CPU pushes 16-bit I/Q baseband pairs into a small FIFO, and the block plays them out at a fixed interpolation rate on adc_clk. Each pair is held for 2^LOG2_INTERP ADC clocks, optionally with linear interpolation between pairs. The output feeds the TX mixer/DAC path as a continuous I/Q stream with a per-sample strobe and status flags.

## Interface
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW pairs.
- LOG2_INTERP, 5: output clocks per input pair = 2^LOG2_INTERP; legal range 1..10.
- START_LEVEL, 8: FIFO level needed to leave IDLE; legal range 1..2^FIFO_AW.

- adc_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- tx_en  in  1  level; high enables playout; low flushes the FIFO and idles.
- tx_wr  in  1  one-cycle pulse that pushes tx_wdata.
- tx_wdata  in  32  {I[15:0], Q[15:0]}, two's complement.
- clr_flags  in  1  pulse; clears tx_underrun and tx_overflow.
- tx_level  out  FIFO_AW+1  current FIFO occupancy.
- tx_full  out  1  tx_level == 2^FIFO_AW.
- tx_running  out  1  high while in RUN.
- tx_avail  out  1  one-cycle pulse when a new pair is loaded into the output stage.
- tx_out_i, tx_out_q  out  16 each  interpolated output, registered.
- tx_underrun  out  1  sticky flag.
- tx_overflow  out  1  sticky flag.

## Operation
- FIFO: synchronous read/write, 2^FIFO_AW x 32 bits.
  - Push on tx_wr when not full. A push while full is dropped and sets tx_overflow.
  - Push and pop in the same cycle leave tx_level unchanged.
- Phase counter: LOG2_INTERP bits; free-runs only in RUN and wraps from 2^LOG2_INTERP-1 to 0.
- States:
  - IDLE: outputs 0, counter 0. Go to RUN when tx_en && tx_level >= START_LEVEL.
  - RUN: when counter == 0, pop one pair and load it; pulse tx_avail the next cycle. If the counter is 0 and the FIFO is empty, set tx_underrun, go to IDLE, and drive outputs to 0.
  - From any state, tx_en low forces IDLE, empties the FIFO (level 0), and drives outputs to 0 on the next edge. It does not change the flags.
- Load: prev <= cur; cur <= popped pair. On entry to RUN, prev and cur both start at 0.
- Arithmetic (per channel): diff = cur - prev, 17-bit signed. acc is (17+LOG2_INTERP)-bit signed.
  - At load: acc <= prev << LOG2_INTERP.
  - Each later RUN cycle: acc <= acc + diff.
  - Output = acc >>> LOG2_INTERP, which always lies between prev and cur, so no saturation is needed.
- Flags: set and clear in the same cycle -> set wins. clr_flags has no other effect.

## Timing
- Reset values: every output 0, state IDLE, FIFO empty.
- The IDLE->RUN decision registers in 1 cycle. The first pop happens in the first RUN cycle (counter 0).
- Pop to tx_avail: 1 cycle. Pop to first output value (prev of the new segment): 2 cycles.
- In steady RUN, tx_avail is exactly periodic at 2^LOG2_INTERP cycles.
- For segment k = 0..2^LOG2_INTERP-1: out = prev + ((cur-prev)*k) >>> LOG2_INTERP.
- Reset asserted mid-RUN: immediate return to reset values; FIFO contents are lost.

## Configuration
- TX_INTERP_LINEAR_EN:
  - Defined: linear interpolation as above.
  - Undefined: zero-order hold, i.e. output = cur for the whole segment. The acc/diff logic is omitted and output changes at the same cycle offset as in linear mode.

## Test plan
- Startup/priming (LOG2_INTERP=2, START_LEVEL=2):
  - 1 push -> stays in IDLE.
  - 2nd push -> tx_running is high 1 cycle later; tx_avail is periodic every 4 cycles.
- Linear ramp: push I = 0, 400, 400 (Q = -I) -> the segment after 400 loads gives out_i 0, 100, 200, 300, then a constant 400 segment; out_q is the negation.
- Zero-order hold (macro undefined), same stimulus -> out_i steps 0 -> 400 with no intermediate values.
- Underrun: START_LEVEL=1, push a single pair -> after its segment, tx_underrun=1, state IDLE, outputs 0. clr_flags -> 0.
- Overflow (FIFO_AW=2): 5 pushes with tx_en=0 -> tx_level=4, tx_full=1, tx_overflow=1. Simultaneous clr_flags and a dropped push -> flag stays 1.
- Flush: deassert tx_en mid-RUN with level 3 -> next cycle tx_level=0, outputs 0, tx_running=0.
